// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: EX-stage partner of the branch predictor.
// Carries each fetched PC's prediction through IF/ID and ID/EX shadow
// registers, checks it against the EX outcome, raises flush/redirect on a
// mispredict, trains the predictor and keeps branch/mispredict statistics.
module branch_resolve_unit #(
  parameter int PC_LENGTH = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_stall,
  input  logic                 i_if_valid,
  input  logic [PC_LENGTH-1:0] i_if_pc,
  input  logic                 i_if_pred_taken,
  input  logic [PC_LENGTH-1:0] i_if_pred_target,
  input  logic                 i_ex_is_br,
  input  logic                 i_ex_taken,
  input  logic [PC_LENGTH-1:0] i_ex_target,
  output logic                 o_flush,
  output logic [PC_LENGTH-1:0] o_redirect_pc,
  output logic                 o_update,
  output logic                 o_taken,
  output logic [PC_LENGTH-1:0] o_pc_ex,
  output logic [PC_LENGTH-1:0] o_target_pc,
  output logic [CNT_WIDTH-1:0] o_br_cnt,
  output logic [CNT_WIDTH-1:0] o_mis_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // IF/ID shadow stage
  logic                 d_valid;
  logic [PC_LENGTH-1:0] d_pc;
  logic                 d_pred_taken;
  logic [PC_LENGTH-1:0] d_pred_target;

  // ID/EX shadow stage
  logic                 e_valid;
  logic [PC_LENGTH-1:0] e_pc;
  logic                 e_pred_taken;
  logic [PC_LENGTH-1:0] e_pred_target;

  logic                 res;
  logic                 br_res;
  logic                 dir_mis;
  logic                 tgt_mis;
  logic                 alias_mis;
  logic                 mispredict;
  logic [PC_LENGTH-1:0] fall_through;

  // Resolve the prediction held in E against the EX outcome.
  always_comb begin
    res          = e_valid & ~i_stall;
    br_res       = res & i_ex_is_br;
    dir_mis      = i_ex_is_br & (i_ex_taken != e_pred_taken);
    tgt_mis      = i_ex_is_br & i_ex_taken & e_pred_taken &
                   (i_ex_target != e_pred_target);
    // A non-branch that the BTB sent elsewhere must be pulled back.
    alias_mis    = ~i_ex_is_br & e_pred_taken;
    mispredict   = dir_mis | tgt_mis | alias_mis;
    fall_through = e_pc + PC_LENGTH'(4);
    o_flush      = res & mispredict;
    // Forced to zero when no flush so the bus is quiet (and zero in reset).
    o_redirect_pc = '0;
    if (o_flush) begin
      o_redirect_pc = (i_ex_is_br & i_ex_taken) ? i_ex_target : fall_through;
    end
  end

  // Shadow pipeline: flush beats stall beats advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_valid       <= 1'b0;
      d_pc          <= '0;
      d_pred_taken  <= 1'b0;
      d_pred_target <= '0;
      e_valid       <= 1'b0;
      e_pc          <= '0;
      e_pred_taken  <= 1'b0;
      e_pred_target <= '0;
    end else if (o_flush) begin
      d_valid <= 1'b0;
      e_valid <= 1'b0;
    end else if (!i_stall) begin
      d_valid       <= i_if_valid;
      d_pc          <= i_if_pc;
      d_pred_taken  <= i_if_pred_taken;
      d_pred_target <= i_if_pred_target;
      e_valid       <= d_valid;
      e_pc          <= d_pc;
      e_pred_taken  <= d_pred_taken;
      e_pred_target <= d_pred_target;
    end
  end

  // Predictor training interface, one cycle behind resolution.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_update    <= 1'b0;
      o_taken     <= 1'b0;
      o_pc_ex     <= '0;
      o_target_pc <= '0;
    end else begin
      o_update <= br_res;
      if (br_res) begin
        o_taken     <= i_ex_taken;
        o_pc_ex     <= e_pc;
        o_target_pc <= i_ex_target;
      end
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_br_cnt  <= '0;
      o_mis_cnt <= '0;
    end else begin
      if (br_res && (o_br_cnt != CNT_MAX)) begin
        o_br_cnt <= o_br_cnt + CNT_WIDTH'(1);
      end
      if (o_flush && (o_mis_cnt != CNT_MAX)) begin
        o_mis_cnt <= o_mis_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule
